qarma64_core: RTL and testbench
===============================

QARMA64_CORE -- requirements
Module: qarma64_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 7, meaning forward rounds r (legal 5..7, sigma1 S-box); elaboration SHALL fail outside this range.
REQ-002 SHALL have parameter OUT_REG, default 1, meaning result held in a dedicated output register (0: output taken directly from the state register).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  core can accept a request.
REQ-007 decrypt  input  1  0 encrypt, 1 decrypt; sampled at accept.
REQ-008 in  input  64  plaintext/ciphertext block.
REQ-009 tweak  input  64  tweak.
REQ-010 key  input  128  {w0[127:64], k0[63:0]}.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  64  result block.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Accept SHALL occur on an edge where in_valid && in_ready; in, tweak, key and decrypt SHALL be captured then and held internally; later input changes SHALL have no effect.
REQ-016 FSM states SHALL be: IDLE, FWD, REFL, BWD, DONE; in_ready = (state==IDLE).
REQ-017 IDLE->FWD on accept; the state register loads in ^ wA, where wA = w0 (encrypt) or w1 (decrypt), and w1 = ROTR64(w0,1) ^ (w0>>63).
REQ-018 FWD SHALL last ROUNDS+1 cycles, one round per cycle: round 0 omits ShuffleCells/MixColumns; rounds 1..ROUNDS-1 use constants c1..c(ROUNDS-1); the final FWD cycle is the whitening round keyed with tweak ^ wB.
REQ-019 REFL SHALL last 1 cycle: ShuffleCells, MixColumns, XOR with the reflector key, inverse ShuffleCells.
REQ-020 BWD SHALL last ROUNDS+1 cycles, mirroring FWD with the inverse tweak schedule, the inverse round function and the alpha constant 0xC0AC29B7C97C50DD.
REQ-021 After the last BWD cycle, the result SHALL be XORed with wB and the FSM SHALL enter DONE, with wB = w1 (encrypt) or w0 (decrypt).
REQ-022 Decrypt core key SHALL be k0 ^ alpha and the reflector key SHALL be MixColumns(k0); encrypt uses k0 for both.
REQ-023 Latency SHALL be exactly 2*ROUNDS+3 cycles from the accept edge to the first edge after which out_valid=1 (17 cycles for ROUNDS=7).
REQ-024 In DONE, out_valid=1 and out SHALL be stable until out_ready; DONE->IDLE on an edge with out_ready=1.
REQ-025 out_ready while out_valid=0 SHALL be ignored.
REQ-026 in_valid while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 The tweak schedule SHALL advance one step per FWD round and reverse one step per BWD round, 64-bit wrap of nibble positions with no carry.
REQ-028 A single shared SubCells datapath SHALL serve both FWD and BWD.
REQ-029 When OUT_REG=1, out SHALL retain the last result after the return to IDLE.

Reset
REQ-030 Reset SHALL force: state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, internal state/tweak/key registers=0.
REQ-031 Reset asserted mid-operation SHALL abort it immediately, with no out_valid pulse afterwards; the first accept after deassertion SHALL behave as from power-up.

Verification
REQ-032 ROUNDS=7, encrypt, in=fb623599da6e8127, tweak=477d469dec0b8762, key=84be85ce9804e94b_ec2802d4e0a488e9 -> out=edf67ff370a483f2 after 17 cycles.
REQ-033 Same key/tweak, decrypt, in=edf67ff370a483f2 -> out=fb623599da6e8127.
REQ-034 ROUNDS=5 and ROUNDS=6 builds, same vector -> out=544b0ab95bda7c3a and a512dd1e4e3ec582 respectively; latency 13 and 15 cycles.
REQ-035 Hold out_ready=0 for 10 cycles after out_valid -> out and out_valid are constant; in_valid pulses in that window are not accepted.
REQ-036 Assert reset at cycle 8 of an operation -> outputs at reset values immediately; the next vector from REQ-032 yields edf67ff370a483f2.
REQ-037 Back-to-back: in_valid held high, out_ready tied 1 -> one accept every 2*ROUNDS+5 cycles, all results correct.

Source files
------------

// File: rtl/qarma64_core.sv
// Iterative QARMA-64 tweakable block cipher: one round per clock, forward half,
// reflector, backward half. The sigma1 S-box is an involution, so one S-box layer serves both halves.
module qarma64_core #(
   parameter int ROUNDS  = 7,
   parameter int OUT_REG = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         decrypt,
   input  logic [63:0]  in,
   input  logic [63:0]  tweak,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out,
   output logic         busy
);

   generate
      if (ROUNDS < 5 || ROUNDS > 7) begin : g_bad_rounds
         $error("qarma64_core: ROUNDS must be in 5..7");
      end
   endgenerate

   localparam logic [2:0]  LAST    = 3'(ROUNDS);
   localparam logic [63:0] ALPHA   = 64'hC0AC29B7C97C50DD;
   // Each nibble i holds the source cell index for destination cell i (cell 0 = MSB nibble).
   localparam logic [63:0] TAU     = 64'h0B6DA1C75E38F492;
   localparam logic [63:0] TAU_INV = 64'h05FAD827BE41639C;
   localparam logic [63:0] H_PERM  = 64'h65EF01237CD489AB;
   localparam logic [63:0] H_INV   = 64'h4567B108CDEF9A23;
   localparam logic [15:0] OMEGA_CELLS = 16'b1101_1000_1001_0100;
   localparam logic [63:0] RC [0:7] = '{
      64'h0000000000000000, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
      64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'h3F84D5B5B5470917, 64'h9216D5D98979FB1B};

   function automatic logic [63:0] permute(input logic [63:0] x, input logic [63:0] p);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         y[63-4*i -: 4] = x[63-4*int'(p[63-4*i -: 4]) -: 4];
      end
      return y;
   endfunction

   // Columns are multiplied by circ(0, rho, rho^2, rho) with rho = 1-bit left rotate of a nibble.
   function automatic logic [63:0] mix_columns(input logic [63:0] x);
      logic [63:0] y;
      logic [3:0]  a, b, c;
      y = '0;
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            a = x[63-4*(4*((row+1)%4)+col) -: 4];
            b = x[63-4*(4*((row+2)%4)+col) -: 4];
            c = x[63-4*(4*((row+3)%4)+col) -: 4];
            y[63-4*(4*row+col) -: 4] = {a[2:0], a[3]} ^ {b[1:0], b[3:2]} ^ {c[2:0], c[3]};
         end
      end
      return y;
   endfunction

   function automatic logic [63:0] tweak_fwd(input logic [63:0] t);
      logic [63:0] y;
      logic [3:0]  b;
      y = permute(t, H_PERM);
      for (int i = 0; i < 16; i++) begin
         if (OMEGA_CELLS[15-i]) begin
            b = y[63-4*i -: 4];
            y[63-4*i -: 4] = {b[0] ^ b[1], b[3:1]};
         end
      end
      return y;
   endfunction

   function automatic logic [63:0] tweak_bwd(input logic [63:0] t);
      logic [63:0] y;
      logic [3:0]  b;
      y = t;
      for (int i = 0; i < 16; i++) begin
         if (OMEGA_CELLS[15-i]) begin
            b = y[63-4*i -: 4];
            y[63-4*i -: 4] = {b[2:0], b[3] ^ b[0]};
         end
      end
      return permute(y, H_INV);
   endfunction

   function automatic logic [3:0] sigma1(input logic [3:0] v);
      case (v)
         4'h0: return 4'hA;   4'h1: return 4'hD;   4'h2: return 4'hE;   4'h3: return 4'h6;
         4'h4: return 4'hF;   4'h5: return 4'h7;   4'h6: return 4'h3;   4'h7: return 4'h5;
         4'h8: return 4'h9;   4'h9: return 4'h8;   4'hA: return 4'h0;   4'hB: return 4'hC;
         4'hC: return 4'hB;   4'hD: return 4'h1;   4'hE: return 4'h2;   default: return 4'h4;
      endcase
   endfunction

   typedef enum logic [2:0] {IDLE, FWD, REFL, BWD, DONE} fsm_t;

   fsm_t        fsm_reg;
   logic [2:0]  cnt_reg;
   logic [63:0] state_reg, tweak_reg, wa_reg, wb_reg, kc_reg, k1_reg;
   logic        ready_reg, valid_reg, busy_reg;

   logic [63:0] w0_in, w1_in, rc, fwd_x, fwd_lin, sub_in, sub_out;
   logic [63:0] tweak_b, bwd_lin, bwd_out, refl_out, result;
   logic        whiten, last_bwd;

   assign w0_in   = key[127:64];
   assign w1_in   = {w0_in[0], w0_in[63:1]} ^ {63'b0, w0_in[63]};
   // The counter reaches LAST on the whitening round of either half; round 0 skips the linear layer.
   assign whiten  = (cnt_reg == LAST);
   assign rc      = RC[cnt_reg];
   assign fwd_x   = state_reg ^ tweak_reg ^ (whiten ? wb_reg : (kc_reg ^ rc));
   assign fwd_lin = (cnt_reg == 3'd0) ? fwd_x : mix_columns(permute(fwd_x, TAU));
   assign sub_in  = (fsm_reg == BWD) ? state_reg : fwd_lin;

   for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      assign sub_out[4*gi +: 4] = sigma1(sub_in[4*gi +: 4]);
   end

   assign tweak_b  = whiten ? tweak_reg : tweak_bwd(tweak_reg);
   assign bwd_lin  = (cnt_reg == 3'd0) ? sub_out : permute(mix_columns(sub_out), TAU_INV);
   assign bwd_out  = bwd_lin ^ tweak_b ^ (whiten ? wa_reg : (kc_reg ^ rc ^ ALPHA));
   assign refl_out = permute(mix_columns(permute(state_reg, TAU)) ^ k1_reg, TAU_INV);
   assign result   = bwd_out ^ wb_reg;
   assign last_bwd = (fsm_reg == BWD) && (cnt_reg == 3'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_reg   <= IDLE;
         cnt_reg   <= '0;
         state_reg <= '0;
         tweak_reg <= '0;
         wa_reg    <= '0;
         wb_reg    <= '0;
         kc_reg    <= '0;
         k1_reg    <= '0;
         ready_reg <= 1'b1;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         case (fsm_reg)
            IDLE: if (in_valid) begin
               state_reg <= in ^ (decrypt ? w1_in : w0_in);
               wa_reg    <= decrypt ? w1_in : w0_in;
               wb_reg    <= decrypt ? w0_in : w1_in;
               kc_reg    <= decrypt ? (key[63:0] ^ ALPHA) : key[63:0];
               k1_reg    <= decrypt ? mix_columns(key[63:0]) : key[63:0];
               tweak_reg <= tweak;
               cnt_reg   <= '0;
               fsm_reg   <= FWD;
               ready_reg <= 1'b0;
               busy_reg  <= 1'b1;
            end
            FWD: begin
               state_reg <= sub_out;
               if (whiten) begin
                  fsm_reg <= REFL;
               end else begin
                  tweak_reg <= tweak_fwd(tweak_reg);
                  cnt_reg   <= cnt_reg + 3'd1;
               end
            end
            REFL: begin
               state_reg <= refl_out;
               fsm_reg   <= BWD;
            end
            BWD: begin
               tweak_reg <= tweak_b;
               if (last_bwd) begin
                  state_reg <= result;
                  fsm_reg   <= DONE;
                  valid_reg <= 1'b1;
               end else begin
                  state_reg <= bwd_out;
                  cnt_reg   <= cnt_reg - 3'd1;
               end
            end
            DONE: if (out_ready) begin
               fsm_reg   <= IDLE;
               valid_reg <= 1'b0;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
            end
            default: fsm_reg <= IDLE;
         endcase
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [63:0] out_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)         out_reg <= '0;
            else if (last_bwd) out_reg <= result;
         end
         assign out = out_reg;
      end else begin : g_out_state
         assign out = state_reg;
      end
   endgenerate

   assign in_ready  = ready_reg;
   assign out_valid = valid_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_qarma64_core.sv
// Directed bench for qarma64_core: published vectors for 5/6/7 rounds, output hold,
// mid-operation reset and back-to-back throughput.
module tb_qarma64_core;

   localparam logic [63:0]  PT  = 64'hfb623599da6e8127;
   localparam logic [63:0]  TW  = 64'h477d469dec0b8762;
   localparam logic [127:0] KEY = 128'h84be85ce9804e94b_ec2802d4e0a488e9;
   localparam logic [63:0]  CT7 = 64'hedf67ff370a483f2;
   localparam logic [63:0]  CT5 = 64'h544b0ab95bda7c3a;
   localparam logic [63:0]  CT6 = 64'ha512dd1e4e3ec582;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             decrypt;
   logic [63:0]      din, tweak;
   logic [127:0]     key;
   logic [2:0]       in_valid_v, out_ready_v, in_ready_v, out_valid_v, busy_v;
   logic [2:0][63:0] out_v;

   int tests_run    = 0;
   int tests_failed = 0;

   // Instance 0: 7 rounds, output register; 1: 5 rounds, output from state; 2: 6 rounds.
   qarma64_core #(.ROUNDS(7), .OUT_REG(1)) dut7 (
      .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .decrypt(decrypt), .in(din), .tweak(tweak), .key(key), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .out(out_v[0]), .busy(busy_v[0]));
   qarma64_core #(.ROUNDS(5), .OUT_REG(0)) dut5 (
      .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .decrypt(decrypt), .in(din), .tweak(tweak), .key(key), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .out(out_v[1]), .busy(busy_v[1]));
   qarma64_core #(.ROUNDS(6), .OUT_REG(1)) dut6 (
      .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .decrypt(decrypt), .in(din), .tweak(tweak), .key(key), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .out(out_v[2]), .busy(busy_v[2]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts one operation on instance d, scrambles all inputs right after the accept
   // edge, and waits (bounded) for out_valid. lat counts edges from accept to out_valid.
   task automatic run_op(input int d, input logic dec, input logic [63:0] blk, output int lat);
      decrypt = dec;
      din     = blk;
      in_valid_v[d] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[d] = 1'b0;
      din     = ~blk;
      decrypt = ~dec;
      tweak   = ~TW;
      key     = ~KEY;
      check($sformatf("busy_after_accept[%0d]", d), 64'(busy_v[d]), 64'd1);
      check($sformatf("ready_after_accept[%0d]", d), 64'(in_ready_v[d]), 64'd0);
      lat = 0;
      while (!out_valid_v[d] && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      tweak = TW;
      key   = KEY;
      $display("[TB] dut%0d %s in=%h -> out=%h latency=%0d", d, dec ? "dec" : "enc", blk, out_v[d], lat);
   endtask

   task automatic release_out(input int d);
      out_ready_v[d] = 1'b1;
      @(posedge clk); #1;
      out_ready_v[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [63:0] hold_out;
      logic saw_valid;
      int hits [3];
      int n_hits;

      reset = 1'b1; in_valid_v = '0; out_ready_v = '0;
      decrypt = 1'b0; din = '0; tweak = TW; key = KEY;
      repeat (2) @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_in_ready[%0d]", d), 64'(in_ready_v[d]), 64'd1);
         check($sformatf("rst_out_valid[%0d]", d), 64'(out_valid_v[d]), 64'd0);
         check($sformatf("rst_busy[%0d]", d), 64'(busy_v[d]), 64'd0);
         check($sformatf("rst_out[%0d]", d), out_v[d], 64'd0);
      end
      reset = 1'b0;
      @(posedge clk); #1;

      // 7-round encrypt / decrypt
      run_op(0, 1'b0, PT, lat);
      check("enc7_latency", 64'(lat), 64'd17);
      check("enc7_out", out_v[0], CT7);
      release_out(0);
      check("enc7_release_ready", 64'(in_ready_v[0]), 64'd1);
      check("enc7_release_valid", 64'(out_valid_v[0]), 64'd0);
      check("enc7_out_retained", out_v[0], CT7);

      run_op(0, 1'b1, CT7, lat);
      check("dec7_latency", 64'(lat), 64'd17);
      check("dec7_out", out_v[0], PT);
      release_out(0);

      // 5- and 6-round builds
      run_op(1, 1'b0, PT, lat);
      check("enc5_latency", 64'(lat), 64'd13);
      check("enc5_out", out_v[1], CT5);
      release_out(1);
      run_op(2, 1'b0, PT, lat);
      check("enc6_latency", 64'(lat), 64'd15);
      check("enc6_out", out_v[2], CT6);
      release_out(2);
      run_op(1, 1'b1, CT5, lat);
      check("dec5_out", out_v[1], PT);
      release_out(1);

      // Result held 10 cycles with out_ready low; in_valid pulses must not be taken
      run_op(0, 1'b0, PT, lat);
      hold_out = out_v[0];
      check("hold_first_out", hold_out, CT7);
      for (int i = 0; i < 10; i++) begin
         in_valid_v[0] = (i % 2 == 0);
         din = {$urandom, $urandom};
         @(posedge clk); #1;
         check($sformatf("hold_valid[%0d]", i), 64'(out_valid_v[0]), 64'd1);
         check($sformatf("hold_out[%0d]", i), out_v[0], CT7);
      end
      in_valid_v[0] = 1'b0;
      release_out(0);
      repeat (3) @(posedge clk); #1;
      check("hold_not_queued_busy", 64'(busy_v[0]), 64'd0);
      check("hold_not_queued_valid", 64'(out_valid_v[0]), 64'd0);

      // out_ready high while no result is pending has no effect
      out_ready_v[0] = 1'b1;
      repeat (2) @(posedge clk); #1;
      check("idle_ready_in_ready", 64'(in_ready_v[0]), 64'd1);
      check("idle_ready_valid", 64'(out_valid_v[0]), 64'd0);
      run_op(0, 1'b0, PT, lat);
      check("ready_held_latency", 64'(lat), 64'd17);
      check("ready_held_out", out_v[0], CT7);
      @(posedge clk); #1;
      out_ready_v[0] = 1'b0;
      check("ready_held_back_idle", 64'(in_ready_v[0]), 64'd1);

      // Reset asserted at cycle 8 of an operation
      decrypt = 1'b0; din = PT; in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      repeat (7) @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
      check("midrst_out_valid", 64'(out_valid_v[0]), 64'd0);
      check("midrst_busy", 64'(busy_v[0]), 64'd0);
      check("midrst_out", out_v[0], 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid_v[0]) saw_valid = 1'b1;
      end
      check("midrst_no_valid_pulse", 64'(saw_valid), 64'd0);
      run_op(0, 1'b0, PT, lat);
      check("after_rst_latency", 64'(lat), 64'd17);
      check("after_rst_out", out_v[0], CT7);
      release_out(0);

      // Back-to-back with in_valid and out_ready held high
      decrypt = 1'b0; din = PT;
      out_ready_v[0] = 1'b1; in_valid_v[0] = 1'b1;
      n_hits = 0;
      hits = '{0, 0, 0};
      for (int cyc = 1; cyc <= 80 && n_hits < 3; cyc++) begin
         @(posedge clk); #1;
         if (out_valid_v[0]) begin
            hits[n_hits] = cyc;
            check($sformatf("b2b_out[%0d]", n_hits), out_v[0], CT7);
            $display("[TB] back-to-back result %0d at cycle %0d out=%h", n_hits, cyc, out_v[0]);
            n_hits++;
         end
      end
      in_valid_v[0] = 1'b0;
      check("b2b_count", 64'(n_hits), 64'd3);
      check("b2b_first", 64'(hits[0]), 64'd18);
      check("b2b_period_1", 64'(hits[1] - hits[0]), 64'd19);
      check("b2b_period_2", 64'(hits[2] - hits[1]), 64'd19);
      @(posedge clk); #1;
      out_ready_v[0] = 1'b0;
      check("b2b_end_idle", 64'(busy_v[0]), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
